// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame state encoding and default frame timing.
// Used by both the DAC and ADC SPI blocks.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    SHIFT = 2'b10,
    GAP   = 2'b11
  } spi_state_e;

  localparam int DEF_WORD_BITS  = 16;
  localparam int DEF_CLK_HALF   = 4;
  localparam int DEF_GAP_CYCLES = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI half-period timer: while enabled, it strobes the end of each clock half.
// fall_o ends a high half and rise_o ends a low half. Both outputs are combinational.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_HALF = DEF_CLK_HALF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          phase_q, phase_d;
  logic          half_end;

  // The phase bit starts at 0 (high half) whenever the generator is re-enabled.
  always_comb begin
    half_end   = en_i && (half_cnt_q == HW'(CLK_HALF - 1));
    half_cnt_d = '0;
    phase_d    = 1'b0;
    if (en_i) begin
      if (half_end) begin
        half_cnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
        phase_d    = phase_q;
      end
    end
    fall_o = half_end && !phase_q;
    rise_o = half_end && phase_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
    end
  end

endmodule

// File: rtl/adc_spi_sender.sv
// SPI mode-0 frame sender: IDLE -> SETUP -> SHIFT -> GAP. Data is sent MSB first and all outputs are registered.
// Define SPI_CS_EN to add the active-low frame select output spi_cs_out.
module adc_spi_sender
  import spi_pkg::*;
#(
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int CLK_HALF   = DEF_CLK_HALF,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 busy,
  output logic                 done,
  output logic                 spi_clock_out,
`ifdef SPI_CS_EN
  output logic                 spi_data_out,
  output logic                 spi_cs_out
`else
  output logic                 spi_data_out
`endif
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int CW = $clog2(max_int(CLK_HALF, GAP_CYCLES) + 1);

  spi_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]        cyc_cnt_q, cyc_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 sdo_q, sdo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           rst_sync_q;
  logic                 ready;
  logic                 clk_rise, clk_fall;
`ifdef SPI_CS_EN
  logic                 cs_q, cs_d;
`endif

  // Reset release goes through two flops, so send is ignored for two cycles after reset drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign ready = rst_sync_q[1];

  spi_clk_gen #(
    .CLK_HALF(CLK_HALF)
  ) u_clk_gen (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (state_q == SHIFT),
    .rise_o(clk_rise),
    .fall_o(clk_fall)
  );

  // The first rising edge is issued on SETUP exit. Later rising edges are issued by the low-half strobes.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SPI_CS_EN
    cs_d      = cs_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (send && ready) begin
          state_d   = SETUP;
          shreg_d   = data_in;
          sdo_d     = data_in[WORD_BITS-1];
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
`ifdef SPI_CS_EN
          cs_d      = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (cyc_cnt_q == CW'(CLK_HALF - 1)) begin
          state_d   = SHIFT;
          sclk_d    = 1'b1;
          bit_cnt_d = BW'(1);
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
          sdo_d   = shreg_q[WORD_BITS-2];
        end else if (clk_rise) begin
          if (bit_cnt_q == BW'(WORD_BITS)) begin
            state_d   = GAP;
            sdo_d     = 1'b0;
            cyc_cnt_d = '0;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
`ifdef SPI_CS_EN
        if (bit_cnt_q == BW'(WORD_BITS) && !sclk_q) begin
          cs_d = 1'b1;
        end
`endif
      end
      GAP: begin
        if (cyc_cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_CS_EN
      cs_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_CS_EN
      cs_q      <= cs_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign spi_clock_out = sclk_q;
  assign spi_data_out  = sdo_q;
`ifdef SPI_CS_EN
  assign spi_cs_out    = cs_q;
`endif

endmodule

// File: doc/adc_spi_sender.md
ADC_SPI_SENDER -- requirements
Module: adc_spi_sender

Interface
REQ-001 SHALL have parameter WORD_BITS, default 16, bits per frame.
REQ-002 SHALL have parameter CLK_HALF, default 4, system clocks per SPI clock half-period (min 2).
REQ-003 SHALL have parameter GAP_CYCLES, default 8, system clocks of idle clock between frames.
REQ-004 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  WORD_BITS  word to transmit, sampled on accepted send.
REQ-007 SHALL have port send  input  1  transmit request; level-sampled.
REQ-008 SHALL have port busy  output  1  high from cycle after acceptance until end of gap.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port spi_clock_out  output  1  SPI clock; idle low.
REQ-011 SHALL have port spi_data_out  output  1  serial data, MSB first.
REQ-012 SHALL have port spi_cs_out  output  1  active-low frame select, only when SPI_CS_EN is defined.

Function
REQ-013 SHALL implement states IDLE, SETUP, SHIFT, GAP.
REQ-014 SHALL, in IDLE with send high, latch data_in into the shift register, drive spi_data_out = data_in[MSB], and enter SETUP; busy high next cycle.
REQ-015 SHALL ignore send in every state other than IDLE; no queueing.
REQ-016 SHALL hold SETUP for CLK_HALF cycles with spi_clock_out low, then enter SHIFT.
REQ-017 SHALL, in SHIFT, drive spi_clock_out high for CLK_HALF cycles, then low for CLK_HALF cycles, per bit (SPI mode 0).
REQ-018 SHALL update spi_data_out to the next bit on the same cycle spi_clock_out falls; data stable across each rising edge.
REQ-019 SHALL emit exactly WORD_BITS rising edges per frame; bit counter width = clog2(WORD_BITS+1), no wrap.
REQ-020 SHALL, after the last falling edge, enter GAP with spi_clock_out low and spi_data_out low.
REQ-021 SHALL hold GAP for GAP_CYCLES cycles, then pulse done for one cycle, deassert busy that cycle, and return to IDLE.
REQ-022 SHALL produce frame length (accept to done) of 1 + CLK_HALF + 2*CLK_HALF*WORD_BITS + GAP_CYCLES cycles.
REQ-023 SHALL accept a send held high in the cycle done pulses on the following cycle (back-to-back frames, gap preserved).
REQ-024 SHALL not alter the in-flight frame if data_in changes after acceptance.

Reset
REQ-025 SHALL, on reset assertion, immediately force state IDLE, busy 0, done 0, spi_clock_out 0, spi_data_out 0, spi_cs_out 1, counters 0.
REQ-026 SHALL abort any in-flight frame on reset without completing a clock pulse or pulsing done.
REQ-027 SHALL not accept send in the first cycle after reset deassertion with reset-release synchronised internally (2 flops).

Configuration
REQ-028 SHALL, with SPI_CS_EN defined, drive spi_cs_out low from SETUP entry through the last falling edge, high during GAP and IDLE.
REQ-029 SHALL, without SPI_CS_EN, omit spi_cs_out; framing relies solely on GAP idle time; all other timing identical.

Structure
REQ-030 SHALL place state encoding (IDLE=2'b00, SETUP=2'b01, SHIFT=2'b10, GAP=2'b11) and default WORD_BITS/CLK_HALF/GAP_CYCLES constants in shared package spi_pkg, reused by the DAC and ADC SPI blocks.
REQ-031 SHALL use one sub-module spi_clk_gen (half-period counter producing rise/fall strobes, enabled only in SHIFT).

Verification
REQ-032 Bench SHALL cover: send with data_in=16'hA55A, defaults -> 16 rising edges, MSB-first bits 1010010101011010, done after 1+4+128+8=141 cycles.
REQ-033 Bench SHALL cover: send held high continuously for 3 frames (16'h0001,16'h8000,16'hFFFF) -> three frames, 8-cycle low-clock gap each, three done pulses.
REQ-034 Bench SHALL cover: send pulsed during SHIFT with data 16'h1234 -> ignored, original frame unchanged, single done.
REQ-035 Bench SHALL cover: reset asserted after 7th rising edge -> same-cycle outputs to reset values, no done, next send yields full clean frame.
REQ-036 Bench SHALL cover: loopback into ADC SPI input block, values 16'h0000, 16'h7FFF, 16'hC3C3 -> its data_out matches each, data_received once per frame.
REQ-037 Bench SHALL cover: with SPI_CS_EN defined -> spi_cs_out falls 4 cycles before first rising edge, rises with last falling edge+1, high in gap.
